// File: rtl/stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_ctrl
// Purpose  : Memory-stage stack sequencer. Owns the architectural stack
//            pointer (SP). Turns PUSH/POP requests from the execute stage
//            into 16-bit data-memory beats and returns popped items to
//            write-back. 32-bit items (PC/flags) move as two beats, 16-bit
//            register items as one. Upstream is stalled (req_ready = 0)
//            whenever a request is in flight.
//
//            Stack convention: a push writes at SP and then decrements SP;
//            a pop increments SP and then reads at SP. A wide item is stored
//            high half at the higher address, low half directly below it.
//
// Optional : `define STACK_GUARD_EN to reject pushes that would drop SP
//            below SP_LIMIT and pops that would raise SP above SP_RESET_VAL.
//            Without it, stack_err is tied low and SP wraps modulo 2^32.
//
// Ports    :
//   clk        in   1       clock, all state on rising edge
//   reset      in   1       synchronous, active-high
//   req_valid  in   1       stack request present
//   req_ready  out  1       high only in IDLE
//   req_pop    in   1       0 = push, 1 = pop
//   req_wide   in   1       1 = 32-bit item (two beats), 0 = 16-bit item
//   req_data   in   32      push data; narrow push uses [15:0]
//   mem_addr   out  ADDR_W  data-memory word address
//   mem_wr     out  1       write strobe
//   mem_rd     out  1       read strobe; mem_rdata valid the next cycle
//   mem_wdata  out  16      write data
//   mem_rdata  in   16      read data
//   pop_valid  out  1       one-cycle pulse, pop_data valid
//   pop_data   out  32      popped item; narrow pop zero-extended
//   sp_out     out  32      current SP
//   stack_err  out  1       one-cycle pulse on a guarded (rejected) request
//
// Revision : 1.0  initial release
// ============================================================================
module stack_mem_ctrl #(
  parameter logic [31:0] SP_RESET_VAL = 32'h000F_FFFF,
  parameter int          ADDR_W       = 20,
  parameter logic [31:0] SP_LIMIT     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_pop,
  input  logic              req_wide,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              pop_valid,
  output logic [31:0]       pop_data,
  output logic [31:0]       sp_out,
  output logic              stack_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH0  = 3'd1,
    S_PUSH1  = 3'd2,
    S_POP0   = 3'd3,
    S_POP1   = 3'd4,
    S_POPCAP = 3'd5
  } state_t;

  state_t              r_state;
  logic [31:0]         r_sp;
  logic                r_wide;
  // Holds the low push half while PUSH0 writes the high half, and the
  // captured low pop half while the high half is being read.
  logic [15:0]         r_lo;

  logic                r_req_ready;
  logic                r_mem_wr;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                r_pop_valid;

  logic [31:0]         w_sp_m1;
  logic [31:0]         w_sp_m2;
  logic [31:0]         w_sp_p1;
  logic [31:0]         w_sp_p2;
  logic                w_accept;
  logic                w_reject;

  // SP neighbours; all arithmetic is modulo 2^32 and the memory address is
  // simply the low ADDR_W bits of the result.
  assign w_sp_m1  = r_sp - 32'd1;
  assign w_sp_m2  = r_sp - 32'd2;
  assign w_sp_p1  = r_sp + 32'd1;
  assign w_sp_p2  = r_sp + 32'd2;

  assign w_accept = req_valid & r_req_ready;

`ifdef STACK_GUARD_EN
  logic [32:0] w_n;
  logic        w_push_under;
  logic        w_pop_over;
  logic        r_stack_err;

  // Compared in 33 bits so the bound checks see the true (non-wrapped)
  // distance from the limits.
  assign w_n          = req_wide ? 33'd2 : 33'd1;
  assign w_push_under = ({1'b0, r_sp} < ({1'b0, SP_LIMIT} + w_n));
  assign w_pop_over   = (({1'b0, r_sp} + w_n) > {1'b0, SP_RESET_VAL});
  assign w_reject     = req_pop ? w_pop_over : w_push_under;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stack_err <= 1'b0;
    end else begin
      r_stack_err <= w_accept & w_reject;
    end
  end

  assign stack_err = r_stack_err;
`else
  logic w_unused_limit;

  assign w_reject       = 1'b0;
  assign stack_err      = 1'b0;
  assign w_unused_limit = ^SP_LIMIT;
`endif

  // Single sequencer. Memory strobes, address and write data are registered
  // and set up one state ahead, so each beat appears in the cycle the state
  // machine occupies the corresponding beat state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sp        <= SP_RESET_VAL;
      r_wide      <= 1'b0;
      r_lo        <= 16'h0000;
      r_req_ready <= 1'b1;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_pop_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A rejected request is consumed without any memory beat.
          if (w_accept && !w_reject) begin
            r_req_ready <= 1'b0;
            r_wide      <= req_wide;
            r_lo        <= req_data[15:0];
            if (!req_pop) begin
              r_state     <= S_PUSH0;
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= r_sp[ADDR_W-1:0];
              r_mem_wdata <= req_wide ? req_data[31:16] : req_data[15:0];
            end else begin
              r_state    <= S_POP0;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_sp_p1[ADDR_W-1:0];
            end
          end
        end

        S_PUSH0: begin
          if (r_wide) begin
            r_state     <= S_PUSH1;
            r_mem_addr  <= w_sp_m1[ADDR_W-1:0];
            r_mem_wdata <= r_lo;
          end else begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 16'h0000;
            r_sp        <= w_sp_m1;
          end
        end

        S_PUSH1: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_wr    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= 16'h0000;
          r_sp        <= w_sp_m2;
        end

        S_POP0: begin
          if (r_wide) begin
            // Read strobe stays high for the high-half read.
            r_state    <= S_POP1;
            r_mem_addr <= w_sp_p2[ADDR_W-1:0];
          end else begin
            r_state     <= S_POPCAP;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_pop_valid <= 1'b1;
          end
        end

        S_POP1: begin
          // Data from the POP0 read (low half) arrives this cycle.
          r_lo        <= mem_rdata;
          r_state     <= S_POPCAP;
          r_mem_rd    <= 1'b0;
          r_mem_addr  <= '0;
          r_pop_valid <= 1'b1;
        end

        S_POPCAP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_pop_valid <= 1'b0;
          r_sp        <= r_wide ? w_sp_p2 : w_sp_p1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_wr    <= 1'b0;
          r_mem_rd    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= 16'h0000;
          r_pop_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign mem_wr    = r_mem_wr;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign pop_valid = r_pop_valid;
  assign sp_out    = r_sp;

  // The final read's data is only available during the POPCAP cycle itself,
  // so the popped item is formed combinationally from mem_rdata while
  // pop_valid is high; it reads as zero otherwise.
  assign pop_data  = !r_pop_valid ? 32'h0000_0000 :
                     r_wide       ? {mem_rdata, r_lo} :
                                    {16'h0000, mem_rdata};

endmodule
`default_nettype wire
